multi_channel_pwm: RTL and testbench
====================================

MULTI_CHANNEL_PWM -- requirements
Module: multi_channel_pwm

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter PWM_HZ, default 25000: PWM carrier frequency in Hz; PERIOD = CLK_HZ/PWM_HZ, integer-truncated, PERIOD >= 2.
REQ-003 SHALL have parameter N_CH, default 2: number of independent motor channels.
REQ-004 SHALL have parameter DUTY_W, default 10: duty resolution; duty is expressed out of 2^DUTY_W.
REQ-005 SHALL have parameter RAMP_STEP, default 8: maximum change of applied duty per PWM period.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-007 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-008 SHALL have port en, input, N_CH bits: per-channel run enable.
REQ-009 SHALL have port duty_tgt, input, N_CH*DUTY_W bits: target duties; channel i occupies bits [i*DUTY_W +: DUTY_W].
REQ-010 SHALL have port load, input, 1 bit: strobe that captures all of duty_tgt.
REQ-011 SHALL have port pwm, output, N_CH bits: registered PWM outputs.
REQ-012 SHALL have port busy, output, N_CH bits: high while a channel's applied duty differs from its target.
REQ-013 SHALL have port period_tick, output, 1 bit: one-cycle pulse on the last cycle of each period.

Function
REQ-014 Shared counter cnt SHALL count 0..PERIOD-1 and wrap to 0; boundary = cycle where cnt == PERIOD-1; period_tick SHALL be high exactly on that cycle.
REQ-015 When load is high, tgt[i] SHALL be registered from duty_tgt for all channels on that edge; new targets take effect at the next boundary only.
REQ-016 Each channel SHALL hold an applied duty cur[i] (DUTY_W bits) and a latched threshold thr[i]; both SHALL update only at a boundary.
REQ-017 Ramp at each boundary: if cur < tgt then cur <= min(cur + RAMP_STEP, tgt); if cur > tgt then cur <= max(cur - RAMP_STEP, tgt); no overflow or underflow permitted (use a DUTY_W+1 bit intermediate).
REQ-018 Threshold at each boundary: thr <= (PERIOD * cur_next) >> DUTY_W, floor, computed at full product width ceil(log2 PERIOD)+DUTY_W; thr is stable for the whole following period (glitch-free duty change).
REQ-019 pwm[i] SHALL be registered: pwm[i] <= en[i] && (cnt < thr[i]); duty 0 gives constant low; no channel reaches 100 %.
REQ-020 Per-channel FSM states:
  - IDLE (en low)
  - RAMP (en high, cur != tgt)
  - HOLD (en high, cur == tgt)
REQ-021 FSM transitions:
  - IDLE -> RAMP or HOLD on en rise (evaluated every cycle)
  - RAMP -> HOLD when cur reaches tgt
  - HOLD -> RAMP when a load changes tgt
  - any state -> IDLE on en fall
REQ-022 busy[i] SHALL be high exactly in RAMP.
REQ-023 en[i] fall SHALL drive pwm[i] low on the next edge and clear cur[i] and thr[i] to 0 immediately, not at a boundary, so a re-enable always ramps up from 0.
REQ-024 load coinciding with a boundary: ramp uses the new tgt value in that same cycle.
REQ-025 en fall coinciding with a boundary: the clear takes priority over the ramp.
REQ-026 Channels SHALL be fully independent apart from the shared cnt.

Reset
REQ-027 rst high SHALL set cnt, cur, tgt, thr, pwm, busy and period_tick to 0 and all FSMs to IDLE on the next edge.
REQ-028 rst SHALL override load, en and any boundary update in the same cycle.
REQ-029 rst asserted mid-ramp SHALL abort the ramp; after rst deasserts, cnt restarts from 0.

Verification (bench parameters CLK_HZ=1000, PWM_HZ=100 giving PERIOD=10, DUTY_W=4, RAMP_STEP=4, N_CH=2)
REQ-030 rst 3 cycles -> pwm=00, busy=00, period_tick=0; afterwards period_tick pulses every 10 cycles on cnt=9.
REQ-031 en=01, duty_tgt ch0=8, load 1 cycle -> busy[0]=1; cur goes 4 then 8 over two boundaries; pwm[0] high 2 cycles in the 1st period, then 5 cycles per period; busy[0] falls with cur=8.
REQ-032 From HOLD at 8, load ch0=2 -> cur steps 4 then 2 (clamped); pwm[0] high 2 cycles, then 1 cycle per period.
REQ-033 en[0] dropped at cnt=1 mid-period -> pwm[0]=0 next edge, busy[0]=0; re-enable -> first period shows cur=4 (ramp from 0).
REQ-034 ch0 tgt=15, ch1 tgt=4, both enabled, rst asserted after 1 boundary -> all outputs 0; after release both channels stay idle until a new load.
REQ-035 load with tgt=12 on the cnt=9 cycle, with en high and cur=0 -> cur=4 at that boundary; thr=2 in the next period.

Source files
------------

// File: rtl/multi_channel_pwm.sv
// Multi-channel PWM generator with a shared period counter.
// Each channel ramps its applied duty toward a loadable target by a bounded
// step per PWM period. The compare threshold is latched once per period, so
// a duty change never produces a runt pulse.
module multi_channel_pwm #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int PWM_HZ    = 25000,
  parameter int N_CH      = 2,
  parameter int DUTY_W    = 10,
  parameter int RAMP_STEP = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH*DUTY_W-1:0]   duty_tgt,
  input  logic                     load,
  output logic [N_CH-1:0]          pwm,
  output logic [N_CH-1:0]          busy,
  output logic                     period_tick
);

  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // PERIOD itself must be representable, even when it is a power of two.
  localparam int PER_W  = $clog2(PERIOD + 1);
  localparam int PROD_W = PER_W + DUTY_W;

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  logic [CNT_W-1:0] cnt;
  logic             boundary;

  // Move cur one bounded step toward tgt. The gap is formed one bit wider,
  // so the step can never wrap past either end of the duty range.
  function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W:0] gap;
    ramp_step = cur;
    if (cur < tgt) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      ramp_step = (int'(gap) <= RAMP_STEP) ? tgt : cur + DUTY_W'(RAMP_STEP);
    end else if (cur > tgt) begin
      gap = {1'b0, cur} - {1'b0, tgt};
      ramp_step = (int'(gap) <= RAMP_STEP) ? tgt : cur - DUTY_W'(RAMP_STEP);
    end
  endfunction

  // floor(PERIOD * duty / 2^DUTY_W). The result is always < PERIOD,
  // so a channel can never reach 100 %.
  function automatic logic [CNT_W-1:0] duty_thr(input logic [DUTY_W-1:0] d);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(PERIOD) * PROD_W'(d);
    duty_thr = CNT_W'(prod >> DUTY_W);
  endfunction

  assign boundary    = (cnt == CNT_W'(PERIOD - 1));
  assign period_tick = boundary;

  // Shared free-running period counter, 0..PERIOD-1.
  always_ff @(posedge clk) begin
    if (rst || boundary) cnt <= '0;
    else                 cnt <= cnt + CNT_W'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DUTY_W-1:0] tgt, cur, tgt_eff, cur_next;
    logic [CNT_W-1:0]  thr;
    logic              pwm_r, busy_r;
    state_t            state;

    // A load on a boundary cycle is already visible to that cycle's ramp.
    assign tgt_eff  = load ? duty_tgt[i*DUTY_W +: DUTY_W] : tgt;
    assign cur_next = boundary ? ramp_step(cur, tgt_eff) : cur;

    // Per-channel duty ramp, threshold latch, PWM output and run-state FSM.
    always_ff @(posedge clk) begin
      if (rst) begin
        tgt    <= '0;
        cur    <= '0;
        thr    <= '0;
        pwm_r  <= 1'b0;
        busy_r <= 1'b0;
        state  <= IDLE;
      end else begin
        if (load) tgt <= duty_tgt[i*DUTY_W +: DUTY_W];
        pwm_r <= en[i] && (cnt < thr);
        // Disabling clears immediately, so a later enable ramps up from zero.
        if (!en[i]) begin
          cur <= '0;
          thr <= '0;
        end else if (boundary) begin
          cur <= cur_next;
          thr <= duty_thr(cur_next);
        end
        case (state)
          IDLE: begin
            if (en[i]) begin
              state  <= (cur_next != tgt_eff) ? RAMP : HOLD;
              busy_r <= (cur_next != tgt_eff);
            end else begin
              busy_r <= 1'b0;
            end
          end
          RAMP: begin
            if (!en[i]) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else if (cur_next == tgt_eff) begin
              state  <= HOLD;
              busy_r <= 1'b0;
            end
          end
          HOLD: begin
            if (!en[i]) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else if (cur_next != tgt_eff) begin
              state  <= RAMP;
              busy_r <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end

    assign pwm[i]  = pwm_r;
    assign busy[i] = busy_r;
  end

endmodule

// File: tb/tb_multi_channel_pwm.sv
// Scoreboard bench for multi_channel_pwm: directed scenarios followed by
// random stimulus, checked against a cycle-level behavioural model.
module tb_multi_channel_pwm;

  localparam int CLK_HZ = 1000, PWM_HZ = 100, N_CH = 2, DUTY_W = 4, STEP = 4;
  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int FULL   = 1 << DUTY_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH-1:0]        en = '0;
  logic [N_CH*DUTY_W-1:0] duty_tgt = '0;
  logic                   load = 1'b0;
  logic [N_CH-1:0]        pwm, busy;
  logic                   period_tick;

  multi_channel_pwm #(
    .CLK_HZ(CLK_HZ), .PWM_HZ(PWM_HZ), .N_CH(N_CH), .DUTY_W(DUTY_W), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .duty_tgt(duty_tgt), .load(load),
    .pwm(pwm), .busy(busy), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH-1:0] pwm;
    logic [N_CH-1:0] busy;
    logic            tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model: phase in the period, applied duty, target, threshold.
  int m_phase;
  int m_cur[N_CH];
  int m_tgt[N_CH];
  int m_thr[N_CH];

  logic [N_CH-1:0] smp_pwm, smp_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  // Predict the outputs seen after the coming clock edge, given the inputs now driven.
  task automatic model_edge();
    exp_t e;
    int   t_eff;
    e.pwm  = '0;
    e.busy = '0;
    if (rst) begin
      m_phase = 0;
      for (int c = 0; c < N_CH; c++) begin
        m_cur[c] = 0; m_tgt[c] = 0; m_thr[c] = 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        t_eff = load ? int'(duty_tgt[c*DUTY_W +: DUTY_W]) : m_tgt[c];
        e.pwm[c] = en[c] && (m_phase < m_thr[c]);
        if (!en[c]) begin
          m_cur[c] = 0;
          m_thr[c] = 0;
        end else if (m_phase == PERIOD - 1) begin
          if (m_cur[c] < t_eff)      m_cur[c] = (t_eff - m_cur[c] > STEP) ? m_cur[c] + STEP : t_eff;
          else if (m_cur[c] > t_eff) m_cur[c] = (m_cur[c] - t_eff > STEP) ? m_cur[c] - STEP : t_eff;
          m_thr[c] = (PERIOD * m_cur[c]) / FULL;
        end
        m_tgt[c]  = t_eff;
        e.busy[c] = en[c] && (m_cur[c] != m_tgt[c]);
      end
      m_phase = (m_phase + 1) % PERIOD;
    end
    e.tick = (m_phase == PERIOD - 1);
    exp_q.push_back(e);
  endtask

  // One cycle: sample outputs away from the edge, drive inputs, predict.
  task automatic step(input logic r, input logic [N_CH-1:0] e_v, input logic ld,
                      input int t0, input int t1);
    @(negedge clk);
    smp_pwm  = pwm;
    smp_busy = busy;
    rst  = r;
    en   = e_v;
    load = ld;
    if (ld) duty_tgt = {DUTY_W'(t1), DUTY_W'(t0)};
    model_edge();
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, 0, 0);
  endtask

  task automatic wait_phase(input int ph);
    while (m_phase != ph) step(1'b0, en, 1'b0, 0, 0);
  endtask

  // Count pwm[ch] highs over one full period.
  task automatic count_highs(input int ch, output int hi);
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step(1'b0, en, 1'b0, 0, 0);
      hi += int'(smp_pwm[ch]);
    end
  endtask

  // Monitor: every edge after stimulus started has exactly one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwm", 32'(pwm), 32'(e.pwm));
        check("busy", 32'(busy), 32'(e.busy));
        check("period_tick", 32'(period_tick), 32'(e.tick));
      end
    end
  end

  initial begin
    int hi;
    logic [N_CH-1:0] e_r;
    m_phase = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_cur[c] = 0; m_tgt[c] = 0; m_thr[c] = 0;
    end

    // Reset for three cycles, then let the counter run idle.
    for (int k = 0; k < 3; k++) step(1'b1, 2'b00, 1'b0, 0, 0);
    hold(25);

    // Ramp ch0 up to 8: steady state is 5 of 10 cycles high.
    wait_phase(3);
    step(1'b0, 2'b01, 1'b0, 0, 0);
    step(1'b0, 2'b01, 1'b1, 8, 0);
    step(1'b0, 2'b01, 1'b0, 0, 0);
    check("busy_after_load", 32'(busy[0]), 32'd1);
    hold(30);
    count_highs(0, hi);
    check("ch0_highs_duty8", 32'(hi), 32'd5);
    check("ch0_idle_busy", 32'(smp_busy[0]), 32'd0);

    // Ramp down to 2 (clamped second step): 1 cycle high per period.
    step(1'b0, 2'b01, 1'b1, 2, 0);
    hold(30);
    count_highs(0, hi);
    check("ch0_highs_duty2", 32'(hi), 32'd1);

    // Drop en mid-period, then re-enable.
    wait_phase(1);
    step(1'b0, 2'b00, 1'b0, 0, 0);
    step(1'b0, 2'b00, 1'b0, 0, 0);
    check("pwm_after_disable", 32'(smp_pwm[0]), 32'd0);
    hold(5);
    step(1'b0, 2'b01, 1'b0, 0, 0);
    hold(25);

    // Both channels running, reset after one boundary, then stay idle.
    step(1'b0, 2'b11, 1'b1, 15, 4);
    wait_phase(PERIOD - 1);
    step(1'b0, 2'b11, 1'b0, 0, 0);
    hold(3);
    step(1'b1, 2'b11, 1'b0, 0, 0);
    hi = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      step(1'b0, 2'b11, 1'b0, 0, 0);
      hi += int'(smp_pwm != 0) + int'(smp_busy != 0);
    end
    check("idle_after_reset", 32'(hi), 32'd0);

    // Load coinciding with a boundary: cur=4 immediately, thr=2 next period.
    step(1'b0, 2'b00, 1'b0, 0, 0);
    step(1'b0, 2'b01, 1'b0, 0, 0);
    wait_phase(PERIOD - 1);
    step(1'b0, 2'b01, 1'b1, 12, 0);
    step(1'b0, 2'b01, 1'b0, 0, 0);
    count_highs(0, hi);
    check("load_on_boundary_highs", 32'(hi), 32'd2);
    hold(15);

    // Random traffic: occasional reset, en toggles, loads on any cycle.
    e_r = en;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) e_r[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      step(($urandom_range(0, 149) == 0), e_r,
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, FULL - 1)), int'($urandom_range(0, FULL - 1)));
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
